cond_logic: RTL and testbench
=============================

COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 The block SHALL expose the following ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- Cond  in  4  instruction condition field, Instr[31:28]
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
- FlagW  in  2  from decoder; [1] writes N,Z; [0] writes C,V
- PCS  in  1  PC written by instruction (branch or Rd=R15)
- NextPC  in  1  unconditional PC advance (fetch)
- RegW  in  1  decoder register-write request
- MemW  in  1  decoder memory-write request
- PCWrite  out  1  gated PC write enable
- RegWrite  out  1  gated register-file write enable
- MemWrite  out  1  gated memory write enable
- Flags  out  4  architectural {N,Z,C,V} register contents
- CondEx  out  1  registered condition-pass bit (CondExDly)
- SkipCount  out  16  count of suppressed write cycles
REQ-002 Clock and reset SHALL be the single clock and synchronous, active-low reset given above; no other clock or asynchronous input.

Function
REQ-003 CondPass SHALL be combinational from Cond and the Flags register: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V; 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 Z|(N!=V); 1110 1; 1111 0.
REQ-004 CondExDly SHALL load CondPass on every rising edge; CondEx output SHALL equal CondExDly.
REQ-005 Flags[3:2] (N,Z) SHALL load ALUFlags[3:2] on a rising edge only when FlagW[1]=1 and CondPass=1; otherwise hold.
REQ-006 Flags[1:0] (C,V) SHALL load ALUFlags[1:0] on a rising edge only when FlagW[0]=1 and CondPass=1; otherwise hold.
REQ-007 Flag-write gating SHALL use combinational CondPass (evaluated against pre-update Flags), not CondExDly.
REQ-008 RegWrite SHALL equal RegW & CondExDly; MemWrite SHALL equal MemW & CondExDly.
REQ-009 PCWrite SHALL equal (PCS & CondExDly) | NextPC; NextPC SHALL never be suppressed.
REQ-010 All three write enables SHALL be combinational from current inputs and registers, zero latency.
REQ-011 SkipCount SHALL increment by 1 on a rising edge when (RegW|MemW|PCS)=1 and CondExDly=0.
REQ-012 SkipCount SHALL saturate at 16'hFFFF; no wrap to 0.
REQ-013 Simultaneous FlagW and suppressed write in one cycle: flags update per REQ-005/006 and counter per REQ-011, independently.
REQ-014 Cond=1111 SHALL behave as never-execute (CondPass=0); no X propagation on any output for any 4-bit Cond.

Reset
REQ-015 When reset=0 at a rising edge: Flags=4'b0000, CondExDly=0, SkipCount=16'h0000, overriding all other updates that cycle.
REQ-016 During and immediately after reset, RegWrite=0 and MemWrite=0; PCWrite SHALL follow NextPC only.
REQ-017 Reset asserted mid-instruction SHALL discard any pending flag write and counter increment in that cycle.

Verification
REQ-018 Reset then Cond=1110, FlagW=11, ALUFlags=1001 -> next cycle Flags=1001, CondEx=1.
REQ-019 Flags=0100 (Z=1), Cond=0001 (NE), RegW=1, PCS=1, NextPC=0 held 2 cycles -> RegWrite=0, PCWrite=0 in 2nd cycle, SkipCount=1 after that edge.
REQ-020 Flags=0000, Cond=1110, FlagW=10, ALUFlags=1111 -> Flags=1100 (C,V unchanged).
REQ-021 Flags=1000, Cond=1010 (GE) -> CondEx=0; Flags=1001 -> CondEx=1; Cond=1100 with Flags=1101 -> CondEx=0.
REQ-022 SkipCount preloaded to FFFE by 3 suppressed cycles (Cond=1111, MemW=1) -> FFFF, stays FFFF; then reset=0 -> 0000.
REQ-023 Cond=1111, NextPC=1, PCS=1 -> PCWrite=1 every cycle; FlagW=11 with ALUFlags=1111 -> Flags unchanged.

Source files
------------

// File: rtl/cond_logic.sv
// rtl/cond_logic.sv - condition check, flag register and write-enable gating
module cond_logic (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  Cond,
  input  logic [3:0]  ALUFlags,
  input  logic [1:0]  FlagW,
  input  logic        PCS,
  input  logic        NextPC,
  input  logic        RegW,
  input  logic        MemW,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic [3:0]  Flags,
  output logic        CondEx,
  output logic [15:0] SkipCount
);

  logic condpass;
  logic condexdly;
  logic n, z, c, v;

  assign {n, z, c, v} = Flags;

  always_comb begin
    condpass = 1'b0;
    case (Cond)
      4'b0000: condpass = z;
      4'b0001: condpass = ~z;
      4'b0010: condpass = c;
      4'b0011: condpass = ~c;
      4'b0100: condpass = n;
      4'b0101: condpass = ~n;
      4'b0110: condpass = v;
      4'b0111: condpass = ~v;
      4'b1000: condpass = c & ~z;
      4'b1001: condpass = ~c | z;
      4'b1010: condpass = (n == v);
      4'b1011: condpass = (n != v);
      4'b1100: condpass = ~z & (n == v);
      4'b1101: condpass = z | (n != v);
      4'b1110: condpass = 1'b1;
      default: condpass = 1'b0;
    endcase
  end

  // Flag writes use the live condition result; the bus enables use the registered one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      Flags     <= 4'b0000;
      condexdly <= 1'b0;
      SkipCount <= 16'h0000;
    end else begin
      condexdly <= condpass;
      if (FlagW[1] && condpass)
        Flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0] && condpass)
        Flags[1:0] <= ALUFlags[1:0];
      if ((RegW || MemW || PCS) && !condexdly && (SkipCount != 16'hFFFF))
        SkipCount <= SkipCount + 16'd1;
    end
  end

  assign CondEx   = condexdly;
  assign RegWrite = RegW & condexdly;
  assign MemWrite = MemW & condexdly;
  assign PCWrite  = (PCS & condexdly) | NextPC;

endmodule

// File: tb/tb_cond_logic.sv
// tb/tb_cond_logic.sv - directed-vector bench for cond_logic
module tb_cond_logic;

  logic        clk;
  logic        reset;
  logic [3:0]  Cond;
  logic [3:0]  ALUFlags;
  logic [1:0]  FlagW;
  logic        PCS;
  logic        NextPC;
  logic        RegW;
  logic        MemW;
  logic        PCWrite;
  logic        RegWrite;
  logic        MemWrite;
  logic [3:0]  Flags;
  logic        CondEx;
  logic [15:0] SkipCount;

  int n_checks = 0;
  int n_fails  = 0;

  cond_logic dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .Flags(Flags), .CondEx(CondEx), .SkipCount(SkipCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    Cond = 4'b1110; ALUFlags = 4'b0000; FlagW = 2'b00;
    PCS = 1'b0; NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0;
  endtask

  // Loads Flags through an always-execute flag-setting cycle.
  task automatic set_flags(input logic [3:0] f);
    idle();
    FlagW = 2'b11; ALUFlags = f;
    tick();
    FlagW = 2'b00;
  endtask

  logic [15:0] pass_1101;

  initial begin
    pass_1101 = 16'h6659;
    idle();

    // Reset with a pending flag write and suppressed-write request
    reset = 1'b0;
    FlagW = 2'b11; ALUFlags = 4'b1111;
    RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; NextPC = 1'b1;
    tick();
    tick();
    check("rst_flags", Flags, 4'b0000);
    check("rst_condex", CondEx, 1'b0);
    check("rst_skip", SkipCount, 16'h0000);
    check("rst_regwrite", RegWrite, 1'b0);
    check("rst_memwrite", MemWrite, 1'b0);
    check("rst_pcwrite_nextpc", PCWrite, 1'b1);
    NextPC = 1'b0;
    #1;
    check("rst_pcwrite_idle", PCWrite, 1'b0);

    // Always-execute full flag write
    idle();
    reset = 1'b1;
    FlagW = 2'b11; ALUFlags = 4'b1001;
    tick();
    check("al_flags", Flags, 4'b1001);
    check("al_condex", CondEx, 1'b1);

    // Partial flag write: only N,Z
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    FlagW = 2'b10; ALUFlags = 4'b1111;
    tick();
    check("nz_only_flags", Flags, 4'b1100);

    // GE / GT behaviour
    set_flags(4'b1000);
    Cond = 4'b1010;
    tick();
    check("ge_n1v0", CondEx, 1'b0);
    set_flags(4'b1001);
    Cond = 4'b1010;
    tick();
    check("ge_n1v1", CondEx, 1'b1);
    set_flags(4'b1101);
    Cond = 4'b1100;
    tick();
    check("gt_z1", CondEx, 1'b0);

    // All condition codes against Flags = N1 Z1 C0 V1
    for (int i = 0; i < 16; i++) begin
      Cond = i[3:0];
      tick();
      check($sformatf("cond_%0h", i), CondEx, pass_1101[i]);
    end
    check("sweep_flags_held", Flags, 4'b1101);

    // Never-execute: PC advance still passes, flags untouched
    Cond = 4'b1111; NextPC = 1'b1; PCS = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("nv_pcwrite_%0d", i), PCWrite, 1'b1);
      tick();
    end
    check("nv_flags", Flags, 4'b1101);

    // NE with Z set: second cycle suppressed and counted
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    set_flags(4'b0100);
    Cond = 4'b0001; RegW = 1'b1; PCS = 1'b1;
    #1;
    check("ne_c1_regwrite", RegWrite, 1'b1);
    tick();
    check("ne_c1_skip", SkipCount, 16'h0000);
    check("ne_c2_regwrite", RegWrite, 1'b0);
    check("ne_c2_pcwrite", PCWrite, 1'b0);
    tick();
    check("ne_c2_skip", SkipCount, 16'h0001);

    // Flag write and suppressed write in the same cycle
    Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0011; PCS = 1'b0;
    tick();
    check("both_flags", Flags, 4'b0011);
    check("both_skip", SkipCount, 16'h0002);

    // Counter saturation
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    Cond = 4'b1111; MemW = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    check("sat_fffe", SkipCount, 16'hFFFE);
    repeat (3) @(posedge clk);
    #1;
    check("sat_ffff", SkipCount, 16'hFFFF);
    check("sat_memwrite", MemWrite, 1'b0);
    reset = 1'b0;
    tick();
    check("sat_reset", SkipCount, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
